// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of core, loader/DMA and memory-side signals around mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;
    logic              gnt;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output c_ack, c_rdata, d_ack, d_rdata,
        output m_we, m_addr, m_wdata,
        output busy, gnt
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  c_ack, c_rdata, d_ack, d_rdata,
        input  m_we, m_addr, m_wdata,
        input  busy, gnt
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way grant logic; round-robin by default, core-first when
// MEM_ARB_FIXED_PRIO_EN is defined.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       valid,
    output logic       win
);

    logic [1:0] elig;

    assign elig = req & ~mask;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_fixed;

    // A held core request blocks the loader even while masked in its ack cycle.
    assign valid        = elig[PORT_CORE] | (elig[PORT_DMA] & ~req[PORT_CORE]);
    assign win          = elig[PORT_CORE] ? PORT_CORE : PORT_DMA;
    assign unused_fixed = ^{clk, rst_n, take};
`else
    logic ptr;

    assign valid = |elig;

    always_comb begin
        if (&elig)
            win = ~ptr;
        else if (elig[PORT_CORE])
            win = PORT_CORE;
        else
            win = PORT_DMA;
    end

    // Pointer holds the last granted port; reset to DMA so the core wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= PORT_DMA;
        else if (take && valid)
            ptr <= win;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and loader/DMA accesses onto one synchronous-read memory
// port. Tie policy selected by MEM_ARB_FIXED_PRIO_EN (see arb_rr2).
//
// state     | meaning
// ST_IDLE   | waiting for an eligible request, winner latched on exit
// ST_ACCESS | address/data driven for MEM_LAT cycles, strobe in first cycle
// ST_RESP   | read data captured, ack registered for the next cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic              gnt_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              c_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              busy_q;

    logic              arb_valid;
    logic              arb_win;
    logic              take;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign take = (state == ST_IDLE);

    // The ack register doubles as the mask so a completed request is not re-issued.
    arb_rr2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.d_req, bus.c_req}),
        .mask  ({d_ack_q, c_ack_q}),
        .take  (take),
        .valid (arb_valid),
        .win   (arb_win)
    );

    assign sel_we    = (arb_win == PORT_DMA) ? bus.d_we    : bus.c_we;
    assign sel_addr  = (arb_win == PORT_DMA) ? bus.d_addr  : bus.c_addr;
    assign sel_wdata = (arb_win == PORT_DMA) ? bus.d_wdata : bus.c_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            gnt_q     <= PORT_DMA;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            m_we_q  <= 1'b0;
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_q     <= arb_win;
                        lat_we    <= sel_we;
                        m_we_q    <= sel_we;
                        m_addr_q  <= sel_addr;
                        m_wdata_q <= sel_wdata;
                        cnt       <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0)
                        state <= ST_RESP;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                ST_RESP: begin
                    if (gnt_q == PORT_DMA) begin
                        d_ack_q <= 1'b1;
                        if (!lat_we)
                            d_rdata_q <= bus.m_rdata;
                    end else begin
                        c_ack_q <= 1'b1;
                        if (!lat_we)
                            c_rdata_q <= bus.m_rdata;
                    end
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;
    assign bus.gnt     = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3) driven by queued
// transactions and checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 64;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          drv_req   [2][2];
    logic          drv_we    [2][2];
    logic [AW-1:0] drv_addr  [2][2];
    logic [DW-1:0] drv_wdata [2][2];

    logic          obs_ack   [2][2];
    logic [DW-1:0] obs_rdata [2][2];
    logic          obs_we    [2];
    logic          obs_busy  [2];
    logic          obs_gnt   [2];
    logic [AW-1:0] obs_addr  [2];

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] mem   [MW];
        logic [DW-1:0] rpipe [LAT];

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        initial for (int i = 0; i < MW; i++) mem[i] = init_word(i);

        // Synchronous-read memory with LAT register stages.
        always @(posedge clk) begin
            if (bus.m_we) mem[bus.m_addr[5:0]] = bus.m_wdata;
            rpipe[0] <= mem[bus.m_addr[5:0]];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end

        assign bus.m_rdata  = rpipe[LAT-1];
        assign bus.c_req    = drv_req[g][0];
        assign bus.c_we     = drv_we[g][0];
        assign bus.c_addr   = drv_addr[g][0];
        assign bus.c_wdata  = drv_wdata[g][0];
        assign bus.d_req    = drv_req[g][1];
        assign bus.d_we     = drv_we[g][1];
        assign bus.d_addr   = drv_addr[g][1];
        assign bus.d_wdata  = drv_wdata[g][1];
        assign obs_ack[g][0]   = bus.c_ack;
        assign obs_ack[g][1]   = bus.d_ack;
        assign obs_rdata[g][0] = bus.c_rdata;
        assign obs_rdata[g][1] = bus.d_rdata;
        assign obs_we[g]   = bus.m_we;
        assign obs_busy[g] = bus.busy;
        assign obs_gnt[g]  = bus.gnt;
        assign obs_addr[g] = bus.m_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Requester drivers and reference model state, per lane.
    txn_t          txq [2][2][$];
    txn_t          pend [2][2];
    bit            drv_pend [2][2];
    bit            drv_busy [2][2];
    bit            drv_latched [2][2];
    int            cyc [2];
    int            gcyc [2];
    int            acyc [2];
    bit            act [2];
    bit            aport [2];
    bit            awe [2];
    bit            last [2];
    bit            exp_gnt [2];
    logic [AW-1:0] aaddr [2];
    logic [DW-1:0] adata [2];
    logic [DW-1:0] exp_rdata [2][2];
    logic [DW-1:0] ref_mem [2][MW];
    bit            glog [2][$];
    int            gat [2][$];

    task automatic model_reset(input int g);
        act[g]     = 1'b0;
        last[g]    = 1'b1;
        exp_gnt[g] = 1'b1;
        cyc[g]     = 0;
        for (int p = 0; p < 2; p++) begin
            exp_rdata[g][p]   = '0;
            drv_req[g][p]     = 1'b0;
            drv_we[g][p]      = 1'b0;
            drv_addr[g][p]    = '0;
            drv_wdata[g][p]   = '0;
            drv_pend[g][p]    = 1'b0;
            drv_busy[g][p]    = 1'b0;
            drv_latched[g][p] = 1'b0;
        end
    endtask

    task automatic model_step(input int g);
        int   lat = lat_of(g);
        bit   eack [2];
        bit   el [2];
        bit   w;
        txn_t t;
        if (act[g] && cyc[g] == gcyc[g] + 1) exp_gnt[g] = aport[g];
        for (int p = 0; p < 2; p++) begin
            eack[p] = act[g] && cyc[g] == acyc[g] && aport[g] == 1'(p);
            if (eack[p] && !awe[g]) exp_rdata[g][p] = adata[g];
        end
        chk($sformatf("L%0d c_ack", g), 32'(obs_ack[g][0]), 32'(eack[0]));
        chk($sformatf("L%0d d_ack", g), 32'(obs_ack[g][1]), 32'(eack[1]));
        chk($sformatf("L%0d c_rdata", g), obs_rdata[g][0], exp_rdata[g][0]);
        chk($sformatf("L%0d d_rdata", g), obs_rdata[g][1], exp_rdata[g][1]);
        chk($sformatf("L%0d busy", g), 32'(obs_busy[g]),
            32'(act[g] && cyc[g] > gcyc[g] && cyc[g] < acyc[g]));
        chk($sformatf("L%0d m_we", g), 32'(obs_we[g]),
            32'(act[g] && awe[g] && cyc[g] == gcyc[g] + 1));
        chk($sformatf("L%0d gnt", g), 32'(obs_gnt[g]), 32'(exp_gnt[g]));
        if (act[g] && cyc[g] > gcyc[g] && cyc[g] < acyc[g])
            chk($sformatf("L%0d m_addr", g), 32'(obs_addr[g]), 32'(aaddr[g]));
        if (act[g] && cyc[g] == acyc[g]) act[g] = 1'b0;

        for (int p = 0; p < 2; p++) begin
            if (eack[p]) begin
                drv_busy[g][p]    = 1'b0;
                drv_latched[g][p] = 1'b0;
            end
            if (!drv_busy[g][p] && !drv_pend[g][p] && txq[g][p].size() > 0) begin
                pend[g][p]     = txq[g][p].pop_front();
                drv_pend[g][p] = 1'b1;
            end
            if (drv_pend[g][p]) begin
                t = pend[g][p];
                if (t.gap > 0) begin
                    t.gap--;
                    pend[g][p] = t;
                end else begin
                    drv_we[g][p]    = t.we;
                    drv_addr[g][p]  = t.addr;
                    drv_wdata[g][p] = t.wdata;
                    drv_pend[g][p]  = 1'b0;
                    drv_busy[g][p]  = 1'b1;
                end
            end
            drv_req[g][p] = drv_busy[g][p];
            // Once latched, the other request fields must be ignored.
            if (drv_latched[g][p]) begin
                drv_we[g][p]    = 1'($urandom_range(0, 1));
                drv_addr[g][p]  = AW'($urandom);
                drv_wdata[g][p] = $urandom;
            end
        end

        if (!act[g]) begin
            el[0] = drv_req[g][0] && !eack[0];
            el[1] = drv_req[g][1] && !eack[1];
`ifdef MEM_ARB_FIXED_PRIO_EN
            el[1] = el[1] && !drv_req[g][0];
`endif
            if (el[0] || el[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = el[0] ? 1'b0 : 1'b1;
`else
                w = (el[0] && el[1]) ? !last[g] : el[1];
`endif
                last[g]  = w;
                act[g]   = 1'b1;
                aport[g] = w;
                gcyc[g]  = cyc[g];
                acyc[g]  = cyc[g] + lat + 2;
                awe[g]   = drv_we[g][w];
                aaddr[g] = drv_addr[g][w];
                if (awe[g]) ref_mem[g][aaddr[g][5:0]] = drv_wdata[g][w];
                else        adata[g] = ref_mem[g][aaddr[g][5:0]];
                drv_latched[g][w] = 1'b1;
                glog[g].push_back(w);
                gat[g].push_back(cyc[g]);
            end
        end
        cyc[g]++;
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) model_reset(g);
            else        model_step(g);
        end
    end

    function automatic txn_t mk_txn(input bit we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
        return t;
    endfunction

    function automatic bit quiet();
        for (int g = 0; g < 2; g++) begin
            if (act[g]) return 1'b0;
            for (int p = 0; p < 2; p++)
                if (drv_busy[g][p] || drv_pend[g][p] || txq[g][p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_both(input int p, input txn_t t);
        txq[0][p].push_back(t);
        txq[1][p].push_back(t);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        forever begin
            @(negedge clk); #2;
            if (quiet()) break;
            n++;
            if (n >= budget) begin
                chk({tag, " timeout"}, 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        for (int g = 0; g < 2; g++) begin
            glog[g].delete();
            gat[g].delete();
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < MW; i++) ref_mem[g][i] = init_word(i);
            model_reset(g);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single core read of a preloaded word.
        push_both(0, mk_txn(1'b0, 16'h0010, 32'h0, 0));
        wait_quiet("t1", 100);
        for (int g = 0; g < 2; g++) chk($sformatf("L%0d t1 c_rdata", g), obs_rdata[g][0], 32'hDEADBEEF);

        // Loader write, then core read-back.
        push_both(1, mk_txn(1'b1, 16'h0004, 32'h12345678, 0));
        wait_quiet("t2w", 100);
        push_both(0, mk_txn(1'b0, 16'h0004, 32'h0, 0));
        wait_quiet("t2r", 100);
        for (int g = 0; g < 2; g++) chk($sformatf("L%0d t2 c_rdata", g), obs_rdata[g][0], 32'h12345678);

        // Both ports requesting continuously from reset.
        do_reset();
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            push_both(0, mk_txn(1'b0, AW'($urandom), 32'h0, 0));
            push_both(1, mk_txn(1'b0, AW'($urandom), 32'h0, 0));
        end
        wait_quiet("t3", 500);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d t3 grants", g), 32'(glog[g].size()), 32'd12);
            for (int i = 0; i < glog[g].size() && i < 12; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                chk($sformatf("L%0d t3 order %0d", g, i), 32'(glog[g][i]), 32'(i >= 6));
`else
                chk($sformatf("L%0d t3 order %0d", g, i), 32'(glog[g][i]), 32'(i % 2));
`endif
            end
        end

        // Core holds req through its ack: next grant one cycle after the ack.
        clear_logs();
        for (int i = 0; i < 3; i++) push_both(0, mk_txn(1'b0, AW'($urandom), 32'h0, 0));
        wait_quiet("t4", 200);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d t4 grants", g), 32'(gat[g].size()), 32'd3);
            for (int i = 1; i < gat[g].size(); i++)
                chk($sformatf("L%0d t4 spacing %0d", g, i), 32'(gat[g][i] - gat[g][i-1]),
                    32'(lat_of(g) + 3));
        end

        // Reset pulse during ACCESS: async return to reset values, no ack.
        push_both(0, mk_txn(1'b0, 16'h0010, 32'h0, 0));
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(obs_busy[0] && obs_busy[1]) && n < 50);
        chk("t5 reached access", 32'(obs_busy[0] && obs_busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d t5 busy", g), 32'(obs_busy[g]), 32'd0);
            chk($sformatf("L%0d t5 m_we", g), 32'(obs_we[g]), 32'd0);
            chk($sformatf("L%0d t5 m_addr", g), 32'(obs_addr[g]), 32'd0);
            chk($sformatf("L%0d t5 c_ack", g), 32'(obs_ack[g][0]), 32'd0);
            chk($sformatf("L%0d t5 d_ack", g), 32'(obs_ack[g][1]), 32'd0);
            chk($sformatf("L%0d t5 c_rdata", g), obs_rdata[g][0], 32'd0);
            chk($sformatf("L%0d t5 d_rdata", g), obs_rdata[g][1], 32'd0);
            chk($sformatf("L%0d t5 gnt", g), 32'(obs_gnt[g]), 32'd1);
        end
        @(negedge clk); #2 rst_n = 1'b1;
        push_both(0, mk_txn(1'b0, 16'h0004, 32'h0, 0));
        wait_quiet("t5r", 100);
        for (int g = 0; g < 2; g++) chk($sformatf("L%0d t5 after", g), obs_rdata[g][0], 32'h12345678);

        // Randomised traffic with gaps and mixed reads/writes.
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < 40; i++)
                    txq[g][p].push_back(mk_txn(1'($urandom_range(0, 1)), AW'($urandom),
                                               $urandom, int'($urandom_range(0, 4))));
        wait_quiet("rand", 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
